// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier arbiter: FSM state encoding and a
// constant-evaluable clog2 used to size the ID and in-flight counter fields.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } arb_state_e;

    // Smallest r with 2**r >= n; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_arbiter_multfix.sv
// Pipelined signed fixed-point multiplier. The full product is formed in the
// first stage and carried through CYCLES registers; the last stage provides
// both the low word and the Q-format rescaled word.
module multfix #(
    parameter int WIDTH  = 35,
    parameter int CYCLES = 6
) (
    input  logic                    clk,
    input  logic signed [WIDTH-1:0] i_a,
    input  logic signed [WIDTH-1:0] i_b,
    output logic        [WIDTH-1:0] o_q_sc,
    output logic        [WIDTH-1:0] o_q_unsc
);

    localparam int PW = 2 * WIDTH;

    logic signed [PW-1:0] r_prod [CYCLES];
    logic                 w_unused_ovf;

    // Multiply in stage 0, then shift the product down the pipe every cycle.
    // NOTE: the data pipe has no reset; validity is tracked by the tag pipe outside.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples the previous one's old value.
        r_prod[0] <= PW'(i_a) * PW'(i_b);
        for (int k = 1; k < CYCLES; k++) begin
            r_prod[k] <= r_prod[k-1];
        end
    end

    assign o_q_unsc = r_prod[CYCLES-1][WIDTH-1:0];
    // Scaled result: product >> (WIDTH-2), keeping the sign and dropping overflowed magnitude bits.
    assign o_q_sc   = {r_prod[CYCLES-1][PW-1], r_prod[CYCLES-1][PW-4:WIDTH-2]};

    // The two bits between the sign and the kept magnitude are deliberately discarded.
    assign w_unused_ovf = ^r_prod[CYCLES-1][PW-2:PW-3];

endmodule

// File: rtl/mult_arbiter_rr_grant.sv
// Round-robin request picker: the first asserted request at or after the
// pointer (with wrap-around) wins. Purely combinational.
module rr_grant #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_gnt,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    // Scan from the pointer upward and stop at the first requester found.
    always_comb begin
        int j;
        // NOTE: every output gets a default before any conditional write, so no latch is inferred.
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(i_ptr) + k) % NREQ;
            if (!o_any && i_req[j]) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one pipelined multiplier among NREQ requesters. Round-robin grant,
// one accept per cycle, a tag pipe parallel to the multiplier carries the
// requester ID and scaled/unscaled select so each product returns to its
// originator exactly CYCLES cycles after its accept.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int WIDTH  = 35,
    parameter int CYCLES = 6,
    parameter int NREQ   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_sc,
    input  logic                  drain,
    output logic [NREQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  idle,
    output logic                  drained
);

    localparam int IDW = clog2(NREQ);
    localparam int CW  = clog2(CYCLES + 1);

    arb_state_e       r_state;
    arb_state_e       w_state_nxt;
    logic [IDW-1:0]   r_rr_ptr;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;

    logic [NREQ-1:0]  w_gnt;
    logic [IDW-1:0]   w_idx;
    logic             w_any;
    logic             w_grant_en;
    logic             w_hs;
    logic             w_strobe;
    logic             w_resp_en;

    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_q_sc;
    logic [WIDTH-1:0] w_q_unsc;

    logic             r_tag_vld [CYCLES];
    logic [IDW-1:0]   r_tag_id  [CYCLES];
    logic             r_tag_sc  [CYCLES];

    rr_grant #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_grant (
        .i_req (req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // Grants only in RUN; a rising drain or an active reset blocks them at once.
    assign w_grant_en = !rst && (r_state == ST_RUN) && !drain;
    assign w_hs       = w_grant_en && w_any;
    assign req_ready  = w_grant_en ? w_gnt : '0;

    // The granted requester's operands reach the multiplier in the accept cycle; zero otherwise.
    assign w_op_a = w_hs ? req_a[int'(w_idx)*WIDTH +: WIDTH] : '0;
    assign w_op_b = w_hs ? req_b[int'(w_idx)*WIDTH +: WIDTH] : '0;

    multfix #(
        .WIDTH  (WIDTH),
        .CYCLES (CYCLES)
    ) u_multfix (
        .clk      (clk),
        .i_a      (w_op_a),
        .i_b      (w_op_b),
        .o_q_sc   (w_q_sc),
        .o_q_unsc (w_q_unsc)
    );

    assign w_strobe = r_tag_vld[CYCLES-1];

    // In-flight count: accepts add, result strobes remove, both together cancel.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_hs && !w_strobe) begin
            w_cnt_nxt = r_cnt + CW'(1);
        end else if (!w_hs && w_strobe) begin
            w_cnt_nxt = r_cnt - CW'(1);
        end
    end

    // Next-state logic; DRAIN looks at the post-cycle count so HALT follows the last strobe directly.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (drain) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!drain) begin
                    w_state_nxt = ST_RUN;
                end else if (w_cnt_nxt == '0) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!drain) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // State, round-robin pointer and in-flight counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_hs) begin
                r_rr_ptr <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
            end
        end
    end

    // Tag pipe shadows the multiplier stage-for-stage and never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CYCLES; k++) begin
                r_tag_vld[k] <= 1'b0;
                r_tag_id[k]  <= '0;
                r_tag_sc[k]  <= 1'b0;
            end
        end else begin
            r_tag_vld[0] <= w_hs;
            r_tag_id[0]  <= w_idx;
            r_tag_sc[0]  <= req_sc[w_idx];
            for (int k = 1; k < CYCLES; k++) begin
                r_tag_vld[k] <= r_tag_vld[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
                r_tag_sc[k]  <= r_tag_sc[k-1];
            end
        end
    end

    // Result routing; reset masks any strobe still sitting in the last stage.
    assign w_resp_en  = w_strobe && !rst;
    assign resp_valid = w_resp_en ? (NREQ'(1) << r_tag_id[CYCLES-1]) : '0;
    assign resp_data  = w_resp_en ? (r_tag_sc[CYCLES-1] ? w_q_sc : w_q_unsc) : '0;

    assign idle    = rst || ((r_cnt == '0) && !w_hs);
    assign drained = !rst && (r_state == ST_HALT);

endmodule
